// File: rtl/vx_icache_mux_pkg.sv
// Shared helpers for the icache pipe multiplexer: width calculations used by
// the top level and the round-robin arbiter.
`ifndef ICACHE_CORE_TAG_WIDTH
`define ICACHE_CORE_TAG_WIDTH 8
`endif

package vx_icache_mux_pkg;

  // Pipe index width; never zero so a one-pipe build still has an index field.
  function automatic int calc_log_pipes(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag width on the merged icache side: {pipe_idx, pipe_tag}.
  function automatic int merged_tag_width(input int tag_w, input int n);
    return tag_w + calc_log_pipes(n);
  endfunction

  // Outstanding counter must hold 0..max_pend inclusive.
  function automatic int pend_width(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter. Priority starts at the rotating pointer and wraps;
// the pointer moves to one past the winner only when a grant is issued.
module vx_rr_arbiter
  import vx_icache_mux_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  requests,
  input  logic                                 enable,
  output logic [NUM_REQS-1:0]                  grant_onehot,
  output logic [calc_log_pipes(NUM_REQS)-1:0]  grant_index,
  output logic                                 grant_valid
);

  localparam int IDX_W = calc_log_pipes(NUM_REQS);

  logic [IDX_W-1:0] ptr;

  // Two passes: requesters at/above the pointer first, then the wrapped ones.
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (enable && !grant_valid && requests[i] && (IDX_W'(i) >= ptr)) begin
        grant_valid     = 1'b1;
        grant_index     = IDX_W'(i);
        grant_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (enable && !grant_valid && requests[i] && (IDX_W'(i) < ptr)) begin
        grant_valid     = 1'b1;
        grant_index     = IDX_W'(i);
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Pointer advances past the winner; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset)
      ptr <= '0;
    else if (grant_valid)
      ptr <= (grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
  end

endmodule

// File: rtl/vx_icache_pipe_mux.sv
// Shares one icache core port among NUM_PIPES fetch pipelines. Requests are
// arbitrated round-robin into a single registered stage with the pipe index
// prepended to the tag; responses are steered back combinationally by that
// index. Per-pipe outstanding counters throttle issue and flag bad responses.
// Optional: ICACHE_PIPE_MUX_PERF_EN adds per-pipe stall-cycle counters.
module vx_icache_pipe_mux
  import vx_icache_mux_pkg::*;
#(
  parameter int NUM_PIPES   = 2,
  parameter int ADDR_WIDTH  = 30,
  parameter int WORD_SIZE   = 4,
  parameter int TAG_WIDTH   = `ICACHE_CORE_TAG_WIDTH,
  parameter int MAX_PENDING = 4
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_PIPES-1:0]                                pipe_req_valid,
  input  logic [NUM_PIPES-1:0][ADDR_WIDTH-1:0]                pipe_req_addr,
  input  logic [NUM_PIPES-1:0][TAG_WIDTH-1:0]                 pipe_req_tag,
  output logic [NUM_PIPES-1:0]                                pipe_req_ready,
  output logic [NUM_PIPES-1:0]                                pipe_rsp_valid,
  output logic [8*WORD_SIZE-1:0]                              pipe_rsp_data,
  output logic [TAG_WIDTH-1:0]                                pipe_rsp_tag,
  input  logic [NUM_PIPES-1:0]                                pipe_rsp_ready,
  output logic                                                icache_req_valid,
  output logic [ADDR_WIDTH-1:0]                               icache_req_addr,
  output logic [merged_tag_width(TAG_WIDTH, NUM_PIPES)-1:0]   icache_req_tag,
  input  logic                                                icache_req_ready,
  input  logic                                                icache_rsp_valid,
  input  logic [8*WORD_SIZE-1:0]                              icache_rsp_data,
  input  logic [merged_tag_width(TAG_WIDTH, NUM_PIPES)-1:0]   icache_rsp_tag,
  output logic                                                icache_rsp_ready,
  output logic                                                busy,
  output logic                                                rsp_err
`ifdef ICACHE_PIPE_MUX_PERF_EN
  ,
  output logic [NUM_PIPES-1:0][31:0]                          perf_stall_cycles
`endif
);

  localparam int LOG_PIPES = calc_log_pipes(NUM_PIPES);
  localparam int MTAG_W    = merged_tag_width(TAG_WIDTH, NUM_PIPES);
  localparam int PW        = pend_width(MAX_PENDING);

  logic [NUM_PIPES-1:0][PW-1:0] pend;
  logic [NUM_PIPES-1:0]         eligible;
  logic [NUM_PIPES-1:0]         inc;
  logic [NUM_PIPES-1:0]         dec;
  logic [NUM_PIPES-1:0]         pend_nz;

  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [MTAG_W-1:0]     out_tag;
  logic                  can_load;

  logic [NUM_PIPES-1:0]  grant_onehot;
  logic [LOG_PIPES-1:0]  grant_index;
  logic                  grant_valid;

  logic [LOG_PIPES-1:0]  rsp_idx;
  logic                  idx_ok;
  logic                  rsp_hs;

  // ---------------- request side ----------------
  // Reset gates the arbiter so no pipe sees ready while the block is held.
  assign can_load = !out_valid || icache_req_ready;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_PIPES)
  ) arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (eligible),
    .enable       (can_load && reset),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  assign pipe_req_ready = grant_onehot;
  assign inc            = pipe_req_valid & pipe_req_ready;

  // Single output stage; loads whenever empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_tag   <= '0;
    end else if (can_load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_addr <= pipe_req_addr[grant_index];
        out_tag  <= {grant_index, pipe_req_tag[grant_index]};
      end
    end
  end

  assign icache_req_valid = out_valid;
  assign icache_req_addr  = out_addr;
  assign icache_req_tag   = out_tag;

  // ---------------- response side ----------------
  assign rsp_idx       = icache_rsp_tag[MTAG_W-1 -: LOG_PIPES];
  assign idx_ok        = (int'(rsp_idx) < NUM_PIPES);
  assign pipe_rsp_data = icache_rsp_data;
  assign pipe_rsp_tag  = icache_rsp_tag[TAG_WIDTH-1:0];

  // Unknown index has no owner: accept it so the core never stalls on it.
  always_comb begin
    icache_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_PIPES; i++)
      if (rsp_idx == LOG_PIPES'(i))
        icache_rsp_ready = pipe_rsp_ready[i];
  end

  assign rsp_hs = icache_rsp_valid && icache_rsp_ready;

  // ---------------- per-pipe state ----------------
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    assign pipe_rsp_valid[i] = icache_rsp_valid && (rsp_idx == LOG_PIPES'(i));
    assign dec[i]            = rsp_hs && (rsp_idx == LOG_PIPES'(i));
    assign pend_nz[i]        = (pend[i] != '0);
    assign eligible[i]       = pipe_req_valid[i] && (pend[i] < PW'(MAX_PENDING));

    // Outstanding count; a response to an idle pipe leaves it at zero.
    always_ff @(posedge clk) begin
      if (!reset)
        pend[i] <= '0;
      else if (inc[i] && !dec[i])
        pend[i] <= pend[i] + 1'b1;
      else if (dec[i] && !inc[i] && pend_nz[i])
        pend[i] <= pend[i] - 1'b1;
    end

`ifdef ICACHE_PIPE_MUX_PERF_EN
    // Saturating count of cycles this pipe wanted to issue but was not taken.
    always_ff @(posedge clk) begin
      if (!reset)
        perf_stall_cycles[i] <= '0;
      else if (pipe_req_valid[i] && !pipe_req_ready[i] && (perf_stall_cycles[i] != '1))
        perf_stall_cycles[i] <= perf_stall_cycles[i] + 32'd1;
    end
`else
    // No stall accounting in this build.
`endif
  end

  // Sticky error: orphan index or response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!reset)
      rsp_err <= 1'b0;
    else if (rsp_hs && (!idx_ok || |(dec & ~pend_nz)))
      rsp_err <= 1'b1;
  end

  assign busy = out_valid || (|pend_nz);

endmodule

// File: tb/tb_vx_icache_pipe_mux.sv
// Directed bench for vx_icache_pipe_mux (3 pipes, 4-bit tags, 4 pending).
// Accepted requests are queued with their expected merged form and popped
// when the icache side handshakes.
module tb_vx_icache_pipe_mux;

  localparam int NP = 3;
  localparam int AW = 30;
  localparam int TW = 4;
  localparam int MW = TW + 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] tag;
  } req_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NP-1:0]         pipe_req_valid;
  logic [NP-1:0][AW-1:0] pipe_req_addr;
  logic [NP-1:0][TW-1:0] pipe_req_tag;
  logic [NP-1:0]         pipe_req_ready;
  logic [NP-1:0]         pipe_rsp_valid;
  logic [31:0]           pipe_rsp_data;
  logic [TW-1:0]         pipe_rsp_tag;
  logic [NP-1:0]         pipe_rsp_ready;
  logic                  icache_req_valid;
  logic [AW-1:0]         icache_req_addr;
  logic [MW-1:0]         icache_req_tag;
  logic                  icache_req_ready;
  logic                  icache_rsp_valid;
  logic [31:0]           icache_rsp_data;
  logic [MW-1:0]         icache_rsp_tag;
  logic                  icache_rsp_ready;
  logic                  busy;
  logic                  rsp_err;
`ifdef ICACHE_PIPE_MUX_PERF_EN
  logic [NP-1:0][31:0]   perf_stall_cycles;
`endif

  int   nvec  = 0;
  int   nfail = 0;
  req_t sb[$];

  always #5 clk = ~clk;

  vx_icache_pipe_mux #(
    .NUM_PIPES   (NP),
    .ADDR_WIDTH  (AW),
    .WORD_SIZE   (4),
    .TAG_WIDTH   (TW),
    .MAX_PENDING (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pipe_req_valid   (pipe_req_valid),
    .pipe_req_addr    (pipe_req_addr),
    .pipe_req_tag     (pipe_req_tag),
    .pipe_req_ready   (pipe_req_ready),
    .pipe_rsp_valid   (pipe_rsp_valid),
    .pipe_rsp_data    (pipe_rsp_data),
    .pipe_rsp_tag     (pipe_rsp_tag),
    .pipe_rsp_ready   (pipe_rsp_ready),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_req_tag   (icache_req_tag),
    .icache_req_ready (icache_req_ready),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_tag   (icache_rsp_tag),
    .icache_rsp_ready (icache_rsp_ready),
    .busy             (busy),
    .rsp_err          (rsp_err)
`ifdef ICACHE_PIPE_MUX_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; sampling is 3 later.
  task automatic settle();
    #3;
  endtask

  // Scoreboard bookkeeping for the upcoming edge, then advance one cycle.
  task automatic step();
    req_t e;
    for (int i = 0; i < NP; i++)
      if (pipe_req_valid[i] && pipe_req_ready[i]) begin
        e.addr = pipe_req_addr[i];
        e.tag  = {2'(i), pipe_req_tag[i]};
        sb.push_back(e);
      end
    if (icache_req_valid && icache_req_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_req", 64'(icache_req_tag), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("sb_req_addr", 64'(icache_req_addr), 64'(e.addr));
        check("sb_req_tag", 64'(icache_req_tag), 64'(e.tag));
      end
    end
    @(posedge clk);
    #1;
    if (!reset) sb.delete();
  endtask

  task automatic do_reset();
    pipe_req_valid = '0;
    reset = 1'b0;
    settle();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    pipe_req_valid   = 3'b001;
    pipe_req_addr    = '0;
    pipe_req_tag     = '0;
    pipe_rsp_ready   = 3'b111;
    icache_req_ready = 1'b1;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    icache_rsp_tag   = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state, with a request pending during reset.
    settle();
    check("rst_req_valid", 64'(icache_req_valid), 64'd0);
    check("rst_pipe_ready", 64'(pipe_req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    pipe_req_valid = '0;
    step();
    reset = 1'b1;

    // Single request from pipe 0 and its response.
    pipe_req_valid   = 3'b001;
    pipe_req_addr[0] = 30'h100;
    pipe_req_tag[0]  = 4'h3;
    settle();
    check("p0_ready", 64'(pipe_req_ready), 64'b001);
    step();
    pipe_req_valid = '0;
    settle();
    check("p0_out_valid", 64'(icache_req_valid), 64'd1);
    check("p0_out_addr", 64'(icache_req_addr), 64'h100);
    check("p0_out_tag", 64'(icache_req_tag), 64'h03);
    check("p0_busy_held", 64'(busy), 64'd1);
    step();
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = 6'h03;
    icache_rsp_data  = 32'hDEADBEEF;
    settle();
    check("p0_rsp_valid", 64'(pipe_rsp_valid), 64'b001);
    check("p0_rsp_tag", 64'(pipe_rsp_tag), 64'h3);
    check("p0_rsp_data", 64'(pipe_rsp_data), 64'hDEADBEEF);
    check("p0_rsp_ready", 64'(icache_rsp_ready), 64'd1);
    check("p0_busy_pend", 64'(busy), 64'd1);
    step();
    icache_rsp_valid = 1'b0;
    settle();
    check("p0_busy_done", 64'(busy), 64'd0);
    check("p0_no_err", 64'(rsp_err), 64'd0);
    step();

    // Round-robin alternation between pipes 0 and 1.
    do_reset();
    pipe_req_valid   = 3'b011;
    pipe_req_addr[0] = 30'h200;
    pipe_req_tag[0]  = 4'h1;
    pipe_req_addr[1] = 30'h300;
    pipe_req_tag[1]  = 4'h2;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr_grant", 64'(pipe_req_ready), (k % 2 == 0) ? 64'b001 : 64'b010);
      step();
    end

    // Backpressure: output held, no new grants.
    icache_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall_ready", 64'(pipe_req_ready), 64'd0);
      check("stall_valid", 64'(icache_req_valid), 64'd1);
      check("stall_addr", 64'(icache_req_addr), 64'h300);
      check("stall_tag", 64'(icache_req_tag), 64'h12);
      step();
    end
    icache_req_ready = 1'b1;

    // Pending limit: pipe 0 fills to 4, then pipe 1 still gets through.
    do_reset();
    pipe_req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("fill_p0", 64'(pipe_req_ready), 64'b001);
      step();
    end
    pipe_req_valid = 3'b011;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("p0_blocked", 64'(pipe_req_ready), 64'b010);
      step();
    end
    pipe_req_valid   = 3'b001;
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = 6'h00;
    settle();
    check("p0_still_blocked", 64'(pipe_req_ready), 64'd0);
    check("p0_drain_rsp", 64'(pipe_rsp_valid), 64'b001);
    step();
    icache_rsp_valid = 1'b0;
    settle();
    check("p0_unblocked", 64'(pipe_req_ready), 64'b001);
    step();
    pipe_req_valid = '0;

    // Response backpressure from the owning pipe.
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = 6'h00;
    pipe_rsp_ready   = 3'b110;
    settle();
    check("rsp_bp", 64'(icache_rsp_ready), 64'd0);

    // Invalid index 3: dropped, flagged, sticky.
    icache_rsp_tag = 6'h35;
    pipe_rsp_ready = 3'b000;
    #1;
    check("bad_idx_ready", 64'(icache_rsp_ready), 64'd1);
    check("bad_idx_valid", 64'(pipe_rsp_valid), 64'd0);
    check("bad_idx_err_pre", 64'(rsp_err), 64'd0);
    step();
    icache_rsp_valid = 1'b0;
    pipe_rsp_ready   = 3'b111;
    settle();
    check("bad_idx_err", 64'(rsp_err), 64'd1);
    step();
    settle();
    check("bad_idx_sticky", 64'(rsp_err), 64'd1);
    check("busy_outstanding", 64'(busy), 64'd1);

    // Reset with requests outstanding clears everything.
    step();
    do_reset();
    settle();
    check("rst2_busy", 64'(busy), 64'd0);
    check("rst2_err", 64'(rsp_err), 64'd0);
    check("rst2_valid", 64'(icache_req_valid), 64'd0);
    pipe_req_valid = 3'b001;
    #1;
    check("rst2_p0_free", 64'(pipe_req_ready), 64'b001);
    step();
    pipe_req_valid = '0;

    // Response to pipe 1 with nothing outstanding.
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = 6'h17;
    settle();
    check("zero_rsp_valid", 64'(pipe_rsp_valid), 64'b010);
    check("zero_rsp_tag", 64'(pipe_rsp_tag), 64'h7);
    step();
    icache_rsp_valid = 1'b0;
    settle();
    check("zero_rsp_err", 64'(rsp_err), 64'd1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
